// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int unsigned ZERO_REG = 0;

  // Decode priority in RUN, highest value wins.
  localparam int unsigned PRIO_MEM_BUSY = 3;
  localparam int unsigned PRIO_BRANCH   = 2;
  localparam int unsigned PRIO_LOAD_USE = 1;
  localparam int unsigned PRIO_NORMAL   = 0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle: hazard sources in, register enables/flushes and debug counters out.
interface hazard_ctrl_if #(
  parameter int REGADDR_WIDTH = 3,
  parameter int CNT_WIDTH     = 16
);
  logic [REGADDR_WIDTH-1:0] id_rs, id_rt, ex_rt;
  logic                     id_uses_rs, id_uses_rt;
  logic                     ex_mem_read, ex_branch_taken, mem_busy;
  logic                     pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
  logic                     mem_timeout;
  logic [CNT_WIDTH-1:0]     stall_cycles, flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold,
           mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold,
           mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    count <= '0;
    else if (inc && count != '1)  count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / taken-branch / memory-busy hazard controller with stuck-memory watchdog
// and saturating stall/flush counters. Hazard outputs are combinational (Mealy).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGADDR_WIDTH = 3,
  parameter int CNT_WIDTH     = 16,
  parameter int TIMEOUT       = 255
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO = WW'(TIMEOUT);

  state_e          state, state_d;
  logic [WW-1:0]   wait_cnt, wait_d, wait_nxt;
  logic            load_use, stall_inc, flush_inc;

  assign load_use = hz.ex_mem_read && (hz.ex_rt != REGADDR_WIDTH'(ZERO_REG)) &&
                    ((hz.id_uses_rs && hz.id_rs == hz.ex_rt) ||
                     (hz.id_uses_rt && hz.id_rt == hz.ex_rt));

  // Busy cycles counted including the current one.
  assign wait_nxt = (state == MEM_WAIT) ? wait_cnt + WW'(1) : WW'(1);

  always_comb begin
    state_d       = state;
    wait_d        = wait_cnt;
    hz.pc_write   = 1'b1;
    hz.ifid_write = 1'b1;
    hz.ifid_flush = 1'b0;
    hz.idex_flush = 1'b0;
    hz.pipe_hold  = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (reset) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (state == ERROR) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.pipe_hold  = 1'b1;
      stall_inc     = 1'b1;
    end else if (hz.mem_busy) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.pipe_hold  = 1'b1;
      stall_inc     = 1'b1;
      wait_d        = wait_nxt;
      state_d       = (wait_nxt >= TO) ? ERROR : MEM_WAIT;
    end else begin
      // MEM_WAIT drops straight into RUN decode so no dead cycle follows a hold.
      state_d = RUN;
      wait_d  = '0;
      if (hz.ex_branch_taken) begin
        hz.ifid_flush = 1'b1;
        hz.idex_flush = 1'b1;
        flush_inc     = 1'b1;
      end else if (load_use) begin
        hz.pc_write   = 1'b0;
        hz.ifid_write = 1'b0;
        hz.idex_flush = 1'b1;
        stall_inc     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
    end
  end

  assign hz.mem_timeout = (state == ERROR);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_inc), .count(hz.stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush_inc), .count(hz.flush_events)
  );
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller that drives the write-enable and flush inputs of the IF/ID and ID/EX pipeline registers and the PC. It decides bubbles from the EX-stage side of the ID/EX register. It detects load-use hazards and taken branches resolved in EX, and freezes the whole pipeline while data memory is busy. A watchdog flags stuck memory accesses, and saturating counters report stall and flush activity for performance debug.

## Interface
- REGADDR_WIDTH, 3, register-address width; register 0 is hard-wired zero
- CNT_WIDTH, 16, width of the performance counters
- TIMEOUT, 255, maximum consecutive mem_busy cycles before the error trips (≥1)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- id_rs, id_rt  in  REGADDR_WIDTH each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REGADDR_WIDTH  load destination in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_busy  in  1  data memory cannot complete the MEM-stage access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID squash
- idex_flush  out  1  ID/EX bubble insert
- pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB
- mem_timeout  out  1  sticky watchdog error
- stall_cycles  out  CNT_WIDTH  saturating count of stall cycles
- flush_events  out  CNT_WIDTH  saturating count of branch flushes

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Outputs are Mealy (state + current inputs).
- Definition: load_use = ex_mem_read & ex_rt≠0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- Priority in RUN: mem_busy > ex_branch_taken > load_use > normal.
- RUN with mem_busy:
  - outputs pipe_hold=1, pc_write=0, ifid_write=0, no flushes
  - next state MEM_WAIT; wait counter loads 1
- RUN with taken branch:
  - outputs ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1
  - flush_events increments; a simultaneous load_use is ignored because the ID instruction is wrong-path
- RUN with load_use:
  - outputs pc_write=0, ifid_write=0, idex_flush=1
  - stall_cycles increments
- RUN, normal: pc_write=1, ifid_write=1, all others 0.
- MEM_WAIT with mem_busy:
  - same outputs as the RUN busy case
  - wait counter increments; when it reaches TIMEOUT, go to ERROR
- MEM_WAIT with mem_busy=0: go to RUN and apply RUN decode this same cycle. A branch held in EX is therefore resolved now.
- stall_cycles increments on every cycle with pipe_hold=1 and on every load-use cycle.
- ERROR:
  - mem_timeout=1, pipe_hold=1, pc_write=0, ifid_write=0
  - exited only by reset
- Counters saturate at all-ones and never wrap.

## Timing
- Hazard outputs are combinational: zero-cycle latency from inputs.
- Counters and mem_timeout update on the clk edge after the qualifying cycle.
- Load-use produces exactly one bubble. On the next cycle the load sits in MEM and load_use deasserts naturally.
- A one-cycle mem_busy pulse gives exactly one hold cycle. MEM_WAIT is entered and exited without any extra dead cycle.
- TIMEOUT=N: mem_busy held for N consecutive cycles trips ERROR on the Nth edge; N-1 cycles does not.
- While reset is high:
  - state=RUN, wait counter=0, counters=0, mem_timeout=0
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0
- Reset mid-MEM_WAIT or in ERROR returns to RUN immediately, with no pending hold.

## Structure
- Shared package hazard_pkg holds:
  - state enum (RUN, MEM_WAIT, ERROR)
  - ZERO_REG constant
  - priority documentation constants
- Sub-module sat_counter (parameter WIDTH; inputs clk, reset, inc; output count) is instantiated twice for stall_cycles and flush_events.
- The wait counter lives inline in the FSM.

## Test plan
- Load r2 in EX (ex_rt=2), ID reads rs=2 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1. Same with ex_rt=0 -> no stall.
- ex_branch_taken=1 with simultaneous load_use -> ifid_flush=idex_flush=1, pc_write=1; flush_events=1, stall_cycles unchanged.
- mem_busy high 3 cycles with TIMEOUT=255 -> pipe_hold=1 for exactly 3 cycles, stall_cycles=3, back to RUN with no extra bubble.
- mem_busy held with TIMEOUT=4 -> mem_timeout rises after the 4th edge and stays high after mem_busy drops until reset.
- Force stall_cycles to all-ones with CNT_WIDTH=4 (15 stalls, then 1 more) -> count stays 15.
- Assert reset during MEM_WAIT -> state RUN, counters 0, flushes high while reset is asserted, normal run on release.
